// File: rtl/dot_matrix_digit_scanner_if.sv
// Signal bundle between digit-producing logic and the dot matrix scanner.
// The scanner takes the slave side; whoever supplies digits takes the master side.
interface dot_matrix_digit_scanner_if;
    logic [3:0]  digit;
    logic        digit_we;
    logic        scroll_en;
    logic        blank;
    logic [3:0]  row_bin;
    logic [15:0] col;
    logic        frame_done;

    modport master (
        output digit, digit_we, scroll_en, blank,
        input  row_bin, col, frame_done
    );

    modport slave (
        input  digit, digit_we, scroll_en, blank,
        output row_bin, col, frame_done
    );
endinterface

// File: rtl/dot_matrix_digit_scanner.sv
// Row-multiplexed 16x16 dot matrix driver for one decimal digit, with a
// frame-synchronous digit buffer and optional rotate-scroll.
module dot_matrix_digit_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int SCROLL_FRAMES  = 8,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input logic clk,
    input logic rst_n,
    dot_matrix_digit_scanner_if.slave bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_MAX  = FW'(SCROLL_FRAMES - 1);
    localparam logic [15:0] COL_OFF = COL_ACTIVE_LOW ? 16'hFFFF : 16'h0000;
    localparam logic [15:0] GL_L   = 16'h0800;
    localparam logic [15:0] GL_R   = 16'h0010;
    localparam logic [15:0] GL_BAR = 16'h0FF0;

    logic [PW-1:0] presc;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    pending;
    logic [3:0]    shadow;
    logic [3:0]    offset;
    logic [3:0]    row_q;
    logic [15:0]   col_q;
    logic          frame_done_q;

    logic          advance;
    logic          frame_end;
    logic [3:0]    next_row;
    logic [3:0]    next_shadow;
    logic [3:0]    next_offset;
    logic [FW-1:0] next_fcnt;

    // Segment bits ordered {a,b,c,d,e,f,g}
    function automatic logic [6:0] segments(input logic [3:0] d);
        case (d)
            4'd0:    segments = 7'b1111110;
            4'd1:    segments = 7'b0110000;
            4'd2:    segments = 7'b1101101;
            4'd3:    segments = 7'b1111001;
            4'd4:    segments = 7'b0110011;
            4'd5:    segments = 7'b1011011;
            4'd6:    segments = 7'b1011111;
            4'd7:    segments = 7'b1110000;
            4'd8:    segments = 7'b1111111;
            4'd9:    segments = 7'b1111011;
            default: segments = 7'b0000000;
        endcase
    endfunction

    function automatic logic [15:0] glyph(input logic [3:0] row, input logic [3:0] d);
        logic [6:0] s;
        s = segments(d);
        case (row)
            4'd1:
                glyph = s[6] ? GL_BAR : ((s[1] ? GL_L : 16'h0) | (s[5] ? GL_R : 16'h0));
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6:
                glyph = (s[1] ? GL_L : 16'h0) | (s[5] ? GL_R : 16'h0);
            4'd7:
                glyph = s[0] ? GL_BAR
                             : (((s[1] | s[2]) ? GL_L : 16'h0) | ((s[5] | s[4]) ? GL_R : 16'h0));
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                glyph = (s[2] ? GL_L : 16'h0) | (s[4] ? GL_R : 16'h0);
            4'd13:
                glyph = s[3] ? GL_BAR : ((s[2] ? GL_L : 16'h0) | (s[4] ? GL_R : 16'h0));
            default:
                glyph = 16'h0000;
        endcase
    endfunction

    // A shift by 16 of a 16-bit value yields zero, so offset 0 needs no special case
    function automatic logic [15:0] pattern(input logic [3:0] row, input logic [3:0] d,
                                            input logic [3:0] off, input logic blk);
        logic [15:0] g;
        logic [15:0] rot;
        g   = glyph(row, d);
        rot = (g << off) | (g >> (5'd16 - {1'b0, off}));
        pattern = (blk ? 16'h0000 : rot) ^ COL_OFF;
    endfunction

    always_comb begin
        advance     = (presc == PRESC_MAX);
        frame_end   = advance && (row_q == 4'd15);
        next_row    = row_q + 4'd1;
        next_shadow = shadow;
        next_offset = offset;
        next_fcnt   = frame_cnt;
        if (frame_end) begin
            next_shadow = pending;
            if (bus.scroll_en) begin
                if (frame_cnt == FCNT_MAX) begin
                    next_fcnt   = '0;
                    next_offset = offset + 4'd1;
                end else begin
                    next_fcnt = frame_cnt + 1'b1;
                end
            end else begin
                next_fcnt   = '0;
                next_offset = 4'd0;
            end
        end
    end

    // Row, column, buffer and scroll state all move together on the advance edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            frame_cnt    <= '0;
            pending      <= 4'hF;
            shadow       <= 4'hF;
            offset       <= 4'd0;
            row_q        <= 4'd0;
            col_q        <= COL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            if (bus.digit_we) begin
                pending <= bus.digit;
            end
            frame_done_q <= frame_end;
            if (advance) begin
                presc     <= '0;
                row_q     <= next_row;
                col_q     <= pattern(next_row, next_shadow, next_offset, bus.blank);
                shadow    <= next_shadow;
                offset    <= next_offset;
                frame_cnt <= next_fcnt;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign bus.row_bin    = row_q;
    assign bus.col        = col_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dot_matrix_digit_scanner.sv
// Scoreboard bench for dot_matrix_digit_scanner: a stroke-drawing reference model
// predicts each cycle's outputs for an active-high and an active-low column instance.
module tb_dot_matrix_digit_scanner;
    localparam int DIV = 4;
    localparam int SF  = 2;

    typedef struct packed {
        logic [3:0]  row;
        logic [15:0] col;
        logic        fd;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [3:0] drv_digit;
    logic drv_we;
    logic drv_scroll;
    logic drv_blank;

    int n_checks;
    int n_pass;

    exp_t sb_q[$];

    int m_presc;
    int m_row;
    int m_pending;
    int m_shadow;
    int m_offset;
    int m_fcnt;
    logic [15:0] m_col;
    logic m_fd;

    string seg_names[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                             "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    dot_matrix_digit_scanner_if bus0();
    dot_matrix_digit_scanner_if bus1();

    assign bus0.digit     = drv_digit;
    assign bus0.digit_we  = drv_we;
    assign bus0.scroll_en = drv_scroll;
    assign bus0.blank     = drv_blank;
    assign bus1.digit     = drv_digit;
    assign bus1.digit_we  = drv_we;
    assign bus1.scroll_en = drv_scroll;
    assign bus1.blank     = drv_blank;

    dot_matrix_digit_scanner #(.SCAN_DIV(DIV), .SCROLL_FRAMES(SF), .COL_ACTIVE_LOW(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dot_matrix_digit_scanner #(.SCAN_DIV(DIV), .SCROLL_FRAMES(SF), .COL_ACTIVE_LOW(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, want);
        end
    endtask

    function automatic bit has_seg(input int d, input byte ch);
        string s;
        if (d > 9) return 1'b0;
        s = seg_names[d];
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == ch) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Draw strokes: a/g/d are bars on rows 1/7/13, f,b span rows 1-7, e,c span rows 7-13
    function automatic logic [15:0] draw_row(input int r, input int d, input int off, input logic blk);
        logic [15:0] bm;
        logic [15:0] out;
        bm = 16'h0000;
        if (r == 1  && has_seg(d, "a")) bm |= 16'h0FF0;
        if (r == 7  && has_seg(d, "g")) bm |= 16'h0FF0;
        if (r == 13 && has_seg(d, "d")) bm |= 16'h0FF0;
        if (r >= 1 && r <= 7) begin
            if (has_seg(d, "f")) bm |= 16'h0800;
            if (has_seg(d, "b")) bm |= 16'h0010;
        end
        if (r >= 7 && r <= 13) begin
            if (has_seg(d, "e")) bm |= 16'h0800;
            if (has_seg(d, "c")) bm |= 16'h0010;
        end
        out = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            out[(i + off) % 16] = bm[i];
        end
        return blk ? 16'h0000 : out;
    endfunction

    function automatic exp_t cur_exp();
        exp_t e;
        e.row = m_row[3:0];
        e.col = m_col;
        e.fd  = m_fd;
        return e;
    endfunction

    task automatic model_reset();
        m_presc   = 0;
        m_row     = 0;
        m_pending = 15;
        m_shadow  = 15;
        m_offset  = 0;
        m_fcnt    = 0;
        m_col     = 16'h0000;
        m_fd      = 1'b0;
    endtask

    task automatic model_step();
        int pend_old;
        pend_old = m_pending;
        if (drv_we) m_pending = int'(drv_digit);
        m_fd = 1'b0;
        if (m_presc == DIV - 1) begin
            m_presc = 0;
            if (m_row == 15) begin
                m_row    = 0;
                m_shadow = pend_old;
                m_fd     = 1'b1;
                if (drv_scroll) begin
                    if (m_fcnt == SF - 1) begin
                        m_fcnt   = 0;
                        m_offset = (m_offset + 1) % 16;
                    end else begin
                        m_fcnt++;
                    end
                end else begin
                    m_fcnt   = 0;
                    m_offset = 0;
                end
            end else begin
                m_row++;
            end
            m_col = draw_row(m_row, m_shadow, m_offset, drv_blank);
        end else begin
            m_presc++;
        end
    endtask

    // Predict at each rising edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            sb_q.push_back(cur_exp());
        end
    end

    // Compare on the falling edge, away from the active edge
    initial begin
        exp_t e;
        logic [15:0] inv;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                inv = ~e.col;
                checkOutput("row_bin",        bus0.row_bin,    e.row);
                checkOutput("col",            bus0.col,        e.col);
                checkOutput("frame_done",     bus0.frame_done, e.fd);
                checkOutput("row_bin_lo",     bus1.row_bin,    e.row);
                checkOutput("col_active_low", bus1.col,        inv);
                checkOutput("frame_done_lo",  bus1.frame_done, e.fd);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] d, input logic we, input logic sc,
                                 input logic bl, input int n);
        drv_digit  = d;
        drv_we     = we;
        drv_scroll = sc;
        drv_blank  = bl;
        @(negedge clk);
        #1;
        drv_we = 1'b0;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Wait until the state the DUT samples next edge matches row/presc
    task automatic wait_model(input int row, input int presc, input int max_cycles);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (m_row == row && m_presc == presc) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("sync_wait", {31'd0, found}, 32'd1);
    endtask

    task automatic async_reset_mid_cycle(input int hold_cycles);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        drv_we = 1'b0;
        model_reset();
        sb_q.delete();
        sb_q.push_back(cur_exp());
        for (int i = 0; i < hold_cycles; i++) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        drv_digit  = 4'd0;
        drv_we     = 1'b0;
        drv_scroll = 1'b0;
        drv_blank  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Idle scan after reset: blank frames, row stepping, frame pulses
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 2 * 16 * DIV);

        // Digit 9 written mid-frame appears from the next frame
        wait_model(5, 0, 100);
        applyStimulus(4'd9, 1'b1, 1'b0, 1'b0, 2 * 16 * DIV + 10);

        // Digit write coinciding with a frame boundary
        applyStimulus(4'd8, 1'b1, 1'b0, 1'b0, 3);
        wait_model(15, DIV - 1, 100);
        applyStimulus(4'd1, 1'b1, 1'b0, 1'b0, 3 * 16 * DIV);

        // Scroll digit 9 through a full offset wrap, then stop scrolling
        applyStimulus(4'd9, 1'b1, 1'b1, 1'b0, 34 * 16 * DIV);
        applyStimulus(4'd9, 1'b0, 1'b0, 1'b0, 2 * 16 * DIV);

        // Digit 0, then blank asserted mid-frame, then released
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b0, 2 * 16 * DIV);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 16 * DIV + 7);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16 * DIV);

        // Out-of-range digit shows blank
        applyStimulus(4'd12, 1'b1, 1'b0, 1'b0, 2 * 16 * DIV);

        // Reset during row 9 with a pending digit that must be lost
        applyStimulus(4'd5, 1'b1, 1'b0, 1'b0, 2 * 16 * DIV);
        wait_model(8, DIV - 1, 100);
        applyStimulus(4'd3, 1'b1, 1'b0, 1'b0, 1);
        async_reset_mid_cycle(3);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 2 * 16 * DIV + 5);

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
